// File: rtl/rpn_pop.sv
// Pop-and-evaluate controller for the RPN calculator stack RAM.
// Reads the top two entries, hands them to the external ALU, writes the result back and pops one.
module rpn_pop #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [ADDR_W-1:0] sp,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wren,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_q,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [1:0]        alu_op,
    input  logic [DATA_W-1:0] alu_out,
    output logic              sp_load,
    output logic [ADDR_W-1:0] sp_next,
    output logic [DATA_W-1:0] result,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StRdB   = 3'd1;
    localparam logic [2:0] StRdA   = 3'd2;
    localparam logic [2:0] StExec  = 3'd3;
    localparam logic [2:0] StWrite = 3'd4;

    // Read data is valid RD_LAT edges after the address edge; the counter spans 0..RD_LAT.
    localparam logic [1:0] LatLast = 2'(RD_LAT);

    logic [2:0]        state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_wren_q, mem_wren_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;
    logic [1:0]        alu_op_q, alu_op_d;
    logic              sp_load_q, sp_load_d;
    logic [ADDR_W-1:0] sp_next_q, sp_next_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              rd_ready;

    assign rd_ready = (cnt_q == LatLast);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        base_d      = base_q;
        mem_addr_d  = mem_addr_q;
        mem_wren_d  = mem_wren_q;
        mem_wdata_d = mem_wdata_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        sp_next_d   = sp_next_q;
        result_d    = result_q;
        err_d       = err_q;
        sp_load_d   = 1'b0;
        done_d      = 1'b0;

        case (state_q)
            StIdle: begin
                if (start) begin
                    if (sp >= ADDR_W'(2)) begin
                        base_d     = sp;
                        alu_op_d   = op;
                        err_d      = 1'b0;
                        mem_addr_d = sp - ADDR_W'(1);
                        cnt_d      = 2'd0;
                        state_d    = StRdB;
                    end else begin
                        // Underflow: flag and finish without touching RAM or the pointer.
                        err_d  = 1'b1;
                        done_d = 1'b1;
                    end
                end
            end

            StRdB: begin
                if (rd_ready) begin
                    alu_b_d    = mem_q;
                    mem_addr_d = base_q - ADDR_W'(2);
                    cnt_d      = 2'd0;
                    state_d    = StRdA;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end

            StRdA: begin
                if (rd_ready) begin
                    alu_a_d = mem_q;
                    cnt_d   = 2'd0;
                    state_d = StExec;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end

            StExec: begin
                result_d    = alu_out;
                mem_wdata_d = alu_out;
                mem_wren_d  = 1'b1;
                state_d     = StWrite;
            end

            StWrite: begin
                mem_wren_d = 1'b0;
                sp_next_d  = base_q - ADDR_W'(1);
                sp_load_d  = 1'b1;
                done_d     = 1'b1;
                state_d    = StIdle;
            end

            default: begin
                mem_wren_d = 1'b0;
                state_d    = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= 2'd0;
            base_q      <= '0;
            mem_addr_q  <= '0;
            mem_wren_q  <= 1'b0;
            mem_wdata_q <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= 2'd0;
            sp_load_q   <= 1'b0;
            sp_next_q   <= '0;
            result_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            base_q      <= base_d;
            mem_addr_q  <= mem_addr_d;
            mem_wren_q  <= mem_wren_d;
            mem_wdata_q <= mem_wdata_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            sp_load_q   <= sp_load_d;
            sp_next_q   <= sp_next_d;
            result_q    <= result_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_wren  = mem_wren_q;
    assign mem_wdata = mem_wdata_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign sp_load   = sp_load_q;
    assign sp_next   = sp_next_q;
    assign result    = result_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_rpn_pop.sv
// Bench for rpn_pop: two instances (RD_LAT 1 and 3) share stimulus, each with its own RAM,
// checked every cycle against a transaction-timeline model of the stack.
module tb_rpn_pop;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic       reset, start;
    logic [1:0] op;
    logic [7:0] sp;
    logic       push_we;
    logic [7:0] push_addr, push_data;
    logic       tmo, end_req;

    logic [7:0] mem_addr [2];
    logic [7:0] mem_wdata[2];
    logic [7:0] mem_q    [2];
    logic [7:0] alu_a    [2];
    logic [7:0] alu_b    [2];
    logic [7:0] alu_out  [2];
    logic [7:0] sp_next  [2];
    logic [7:0] result   [2];
    logic [1:0] alu_op   [2];
    logic       mem_wren [2];
    logic       sp_load  [2];
    logic       busy     [2];
    logic       done     [2];
    logic       err      [2];

    logic [7:0] ram  [2][256];
    logic [7:0] qpipe[2][3];

    function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                         input logic [1:0] o);
        case (o)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a & b;
            default: return a | b;
        endcase
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        rpn_pop #(
            .ADDR_W(8),
            .DATA_W(8),
            .RD_LAT((g == 0) ? 1 : 3)
        ) u_dut (
            .CLOCK_50 (clk),
            .reset    (reset),
            .start    (start),
            .op       (op),
            .sp       (sp),
            .mem_addr (mem_addr[g]),
            .mem_wren (mem_wren[g]),
            .mem_wdata(mem_wdata[g]),
            .mem_q    (mem_q[g]),
            .alu_a    (alu_a[g]),
            .alu_b    (alu_b[g]),
            .alu_op   (alu_op[g]),
            .alu_out  (alu_out[g]),
            .sp_load  (sp_load[g]),
            .sp_next  (sp_next[g]),
            .result   (result[g]),
            .busy     (busy[g]),
            .done     (done[g]),
            .err      (err[g])
        );
    end

    always_comb begin
        for (int i = 0; i < 2; i++) alu_out[i] = alu_f(alu_a[i], alu_b[i], alu_op[i]);
        mem_q[0] = qpipe[0][0];
        mem_q[1] = qpipe[1][2];
    end

    // Stack RAM per instance; the push port owns it while the controller is idle.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            qpipe[i][0] <= ram[i][mem_addr[i]];
            qpipe[i][1] <= qpipe[i][0];
            qpipe[i][2] <= qpipe[i][1];
            if (busy[i] && mem_wren[i]) ram[i][mem_addr[i]] <= mem_wdata[i];
            else if (push_we) ram[i][push_addr] <= push_data;
        end
    end

    // ---------------- model + checker ----------------
    int         n_checks = 0;
    int         n_fail = 0;
    int         ph[2];
    int         opcnt[2];
    int         cidx[2];
    logic       ram_chk[2];
    logic [7:0] base[2], e_addr[2], e_wdata[2], e_a[2], e_b[2], e_spn[2], e_res[2];
    logic [1:0] e_op[2];
    logic       e_wren[2], e_spl[2], e_busy[2], e_done[2], e_err[2];
    logic [7:0] mst[2][256];
    logic [31:0] lit_res[6] = '{32'd8, 32'd2, 32'd44, 32'd15, 32'd246, 32'd7};
    logic [31:0] lit_spn[6] = '{32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd3};

    task automatic chk(input string nm, input int i, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[dut%0d] at %0t: got %0d, expected %0d", nm, i, $time, act, exp);
        end
    endtask

    initial begin
        int r;
        logic [7:0] wa;
        for (int i = 0; i < 2; i++) begin
            ph[i] = -1; opcnt[i] = 0; cidx[i] = 99; ram_chk[i] = 1'b0;
            for (int a = 0; a < 256; a++) mst[i][a] = 8'd0;
        end
        forever begin
            @(posedge clk);
            for (int i = 0; i < 2; i++) begin
                r = (i == 0) ? 1 : 3;
                ram_chk[i] = 1'b0;
                if (push_we) mst[i][push_addr] = push_data;
                if (reset) begin
                    ph[i] = -1; base[i] = 0; e_addr[i] = 0; e_wdata[i] = 0; e_a[i] = 0;
                    e_b[i] = 0; e_spn[i] = 0; e_res[i] = 0; e_op[i] = 0; e_wren[i] = 0;
                    e_spl[i] = 0; e_busy[i] = 0; e_done[i] = 0; e_err[i] = 0;
                end else begin
                    e_done[i] = 1'b0;
                    e_spl[i]  = 1'b0;
                    if (ph[i] < 0) begin
                        if (start && sp >= 8'd2) begin
                            ph[i] = 0; base[i] = sp; e_op[i] = op; e_err[i] = 1'b0;
                            e_addr[i] = sp - 8'd1; e_busy[i] = 1'b1;
                        end else if (start) begin
                            e_err[i] = 1'b1; e_done[i] = 1'b1;
                        end
                    end else begin
                        ph[i]++;
                        if (ph[i] == 1 + r) begin
                            e_b[i] = mst[i][base[i] - 8'd1];
                            e_addr[i] = base[i] - 8'd2;
                        end
                        if (ph[i] == 2 + 2 * r) e_a[i] = mst[i][base[i] - 8'd2];
                        if (ph[i] == 3 + 2 * r) begin
                            e_res[i] = alu_f(e_a[i], e_b[i], e_op[i]);
                            e_wdata[i] = e_res[i];
                            e_wren[i] = 1'b1;
                        end
                        if (ph[i] == 4 + 2 * r) begin
                            e_wren[i] = 1'b0; e_spn[i] = base[i] - 8'd1; e_spl[i] = 1'b1;
                            e_done[i] = 1'b1; e_busy[i] = 1'b0; ph[i] = -1;
                            mst[i][base[i] - 8'd2] = e_res[i];
                            ram_chk[i] = 1'b1; cidx[i] = opcnt[i]; opcnt[i]++;
                        end
                    end
                end
            end
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                chk("mem_addr", i, 32'(mem_addr[i]), 32'(e_addr[i]));
                chk("mem_wren", i, 32'(mem_wren[i]), 32'(e_wren[i]));
                chk("mem_wdata", i, 32'(mem_wdata[i]), 32'(e_wdata[i]));
                chk("alu_a", i, 32'(alu_a[i]), 32'(e_a[i]));
                chk("alu_b", i, 32'(alu_b[i]), 32'(e_b[i]));
                chk("alu_op", i, 32'(alu_op[i]), 32'(e_op[i]));
                chk("sp_load", i, 32'(sp_load[i]), 32'(e_spl[i]));
                chk("sp_next", i, 32'(sp_next[i]), 32'(e_spn[i]));
                chk("result", i, 32'(result[i]), 32'(e_res[i]));
                chk("busy", i, 32'(busy[i]), 32'(e_busy[i]));
                chk("done", i, 32'(done[i]), 32'(e_done[i]));
                chk("err", i, 32'(err[i]), 32'(e_err[i]));
                if (ram_chk[i]) begin
                    wa = base[i] - 8'd2;
                    chk("ram_writeback", i, 32'(ram[i][wa]), 32'(mst[i][wa]));
                    if (cidx[i] < 6) begin
                        chk("model_pin", i, 32'(e_res[i]), lit_res[cidx[i]]);
                        chk("lit_result", i, 32'(result[i]), lit_res[cidx[i]]);
                        chk("lit_sp_next", i, 32'(sp_next[i]), lit_spn[cidx[i]]);
                    end
                end
            end
            if (end_req) begin
                chk("no_timeout", 0, 32'(tmo), 32'd0);
                chk("directed_ops_done", 0, 32'(opcnt[0] >= 6), 32'd1);
                $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
                $finish;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic push(input logic [7:0] a, input logic [7:0] d);
        push_we = 1'b1; push_addr = a; push_data = d;
        @(negedge clk);
        push_we = 1'b0;
    endtask

    task automatic run(input logic [7:0] s, input logic [1:0] o, input bit poke);
        sp = s; op = o; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 60 && (busy[0] || busy[1]); c++) begin
            start = (poke && c == 1);
            @(negedge clk);
        end
        if (busy[0] || busy[1]) tmo = 1'b1;
        start = 1'b0;
    endtask

    // Accept, poke start while busy, then reset mid-read.
    task automatic abort(input logic [7:0] s, input logic [1:0] o);
        sp = s; op = o; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int n;
        reset = 1'b1; start = 1'b0; op = 2'd0; sp = 8'd0;
        push_we = 1'b0; push_addr = 8'd0; push_data = 8'd0; tmo = 1'b0; end_req = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        push(8'd0, 8'd5);   push(8'd1, 8'd3);   run(8'd2, 2'd0, 1'b1);
        push(8'd0, 8'd5);   push(8'd1, 8'd3);   run(8'd2, 2'd1, 1'b0);
        push(8'd0, 8'd200); push(8'd1, 8'd100); run(8'd2, 2'd0, 1'b0);
        run(8'd1, 2'd0, 1'b0);
        push(8'd0, 8'd7);   push(8'd1, 8'd9);   run(8'd2, 2'd3, 1'b0);
        push(8'd0, 8'd10);  push(8'd1, 8'd20);  abort(8'd2, 2'd0);
        run(8'd2, 2'd1, 1'b0);
        push(8'd0, 8'd1); push(8'd1, 8'd2); push(8'd2, 8'd3); push(8'd3, 8'd4);
        run(8'd4, 2'd0, 1'b0);

        for (int t = 0; t < 40; t++) begin
            n = $urandom_range(0, 6);
            for (int j = 0; j < n; j++) push(8'(j), 8'($urandom));
            if (n >= 2 && $urandom_range(0, 7) == 0) abort(8'(n), 2'($urandom_range(0, 3)));
            else run(8'(n), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        end_req = 1'b1;
        repeat (4) @(negedge clk);
        $display("FAIL end_of_test: checker did not finish, got running, expected finished");
        $fatal(1);
    end

endmodule

// File: doc/rpn_pop.md
# rpn_pop

Pop-and-evaluate controller for the RPN calculator: the read side of the operand stack RAM, complementing the push path that writes switch values into it. On an operator request it reads the top two stack entries (A = second from top, B = top) and presents them to the external combinational ALU. It then writes `A op B` back into A's slot and tells the push side to drop the stack pointer by one. It owns the stack RAM port only while `busy` is high; the top level muxes the RAM port to this block while `busy`=1.

## Interface
- `ADDR_W`, 8, stack RAM address width (also stack pointer width).
- `DATA_W`, 8, stack entry / operand width.
- `RD_LAT`, 1, RAM read pipeline depth; allowed range 1..3.

Ports:
- `CLOCK_50`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high (top level drives it from `~KEY[3]`).
- `start`  in  1  operator request, sampled every edge.
- `op`  in  2  ALU opcode, latched at an accepted `start`.
- `sp`  in  ADDR_W  current stack pointer: next free address, equal to the entry count.
- `mem_addr`  out  ADDR_W  RAM address (registered).
- `mem_wren`  out  1  RAM write enable (registered).
- `mem_wdata`  out  DATA_W  RAM write data (registered).
- `mem_q`  in  DATA_W  RAM read data.
- `alu_a`, `alu_b`  out  DATA_W  registered operands to the ALU.
- `alu_op`  out  2  latched opcode to the ALU.
- `alu_out`  in  DATA_W  combinational ALU result.
- `sp_load`  out  1  one-cycle pulse: push side sets its pointer to `sp_next`.
- `sp_next`  out  ADDR_W  new stack pointer value.
- `result`  out  DATA_W  last computed value; held until the next operation.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `done`  out  1  one-cycle pulse at completion, success or error.
- `err`  out  1  stack underflow flag; sticky.

## Operation
- States: IDLE, RD_B, RD_A, EXEC, WRITE. Every output is registered.
- IDLE, `start`=1, `sp`>=2:
  - latch `base`<=`sp` and `alu_op`<=`op`; clear `err`.
  - `mem_addr`<=`sp`-1; clear the wait counter; go to RD_B.
- IDLE, `start`=1, `sp`<2 (underflow):
  - `err`<=1, `done`<=1 for one cycle; stay in IDLE.
  - No RAM access, no `sp_load`.
- RD_B: wait counter increments each edge.
  - On the (RD_LAT+1)-th edge after `mem_addr` was set: `alu_b`<=`mem_q`, `mem_addr`<=`base`-2, clear the counter, go to RD_A.
- RD_A: same wait.
  - On the (RD_LAT+1)-th edge: `alu_a`<=`mem_q`, go to EXEC.
- EXEC: one edge.
  - `result`<=`alu_out`, `mem_wdata`<=`alu_out`, `mem_wren`<=1.
  - `mem_addr` stays at `base`-2; go to WRITE.
- WRITE: one edge.
  - `mem_wren`<=0, `sp_next`<=`base`-1, `sp_load`<=1, `done`<=1; go to IDLE.
- Arithmetic belongs to the ALU. This block passes `alu_out` through unchanged; results wrap mod 2^DATA_W.
- `start` is ignored while `busy`=1: no queuing, no error.
- `sp` is sampled only at acceptance. Later changes are ignored; the push side must not write while `busy`=1.
- Reset at any cycle, mid-operation included: next edge returns to IDLE and clears every output.
  - No write is completed after reset is seen, and no `sp_load` is issued.
- Reset values: all outputs 0 (`mem_addr`, `mem_wren`, `mem_wdata`, `alu_a`, `alu_b`, `alu_op`, `sp_load`, `sp_next`, `result`, `busy`, `done`, `err`).

## Timing
- Edge numbering: E0 is the edge that accepts `start`. R = RD_LAT.
- B is captured at E(1+R). A is captured at E(2+2R). EXEC is at E(3+2R).
- `mem_wren` is high for exactly one cycle, between E(3+2R) and E(4+2R).
- `done`, `sp_load` and valid `sp_next` are high for the one cycle after E(4+2R).
  - With R=1, that is the cycle after E6.
- `busy` is high from after E0 until after E(4+2R). It is low in the same cycle `done` is high.
- Earliest next acceptance: E(5+2R).
- Underflow: `done` and `err` rise after E0; `busy` never rises.

## Test plan
- Preload mem[0]=5, mem[1]=3, `sp`=2, op=add, R=1, start -> mem[0]=8, `sp_next`=1, `sp_load`+`done` after E6, `result`=8, one `mem_wren` pulse only.
- Same stack, op=sub -> mem[0]=2 (A-B = 5-3), `alu_a`=5, `alu_b`=3.
- mem[0]=200, mem[1]=100, add -> mem[0]=44 (wrap), `err`=0.
- `sp`=1, start -> `err`=1 and `done` pulse after E0, `mem_wren` never asserted, no `sp_load`. Then a valid start with `sp`=2 -> `err` clears after acceptance.
- Assert `reset` during RD_A -> IDLE next edge, all outputs 0, RAM contents unchanged, no `sp_load`. `start` pulses during `busy` produce no second operation.
- R=3, 4 entries, `sp`=4, add -> writes mem[2] at E(3+2R)=E9, `sp_next`=3, `done` after E10.
